// File: rtl/uart_rx_fifo.sv
// UART receive path: 2-flop synchronizer, 8N1 deframer and FIFO with first-word fall-through.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit sample point.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 286,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic               lpc_clk,
  input  logic               lpc_rst,
  input  logic               uart_rx,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   count,
  output logic               overrun,
  output logic               frame_err,
  input  logic               err_clr,
  output logic               rx_active
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned MID   = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned LAT   = 1;
`else
  localparam int unsigned LAT   = 0;
`endif
  localparam logic [CW-1:0] START_PT = CW'(MID + LAT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic sync1_q, rxs_q, rxs_prev_q;
  logic samp;

`ifdef UART_RX_MAJORITY_EN
  logic rxs_prev2_q;

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) rxs_prev2_q <= 1'b1;
    else          rxs_prev2_q <= rxs_prev_q;
  end

  // Decision is taken one clock after the nominal point so the vote spans -1/0/+1.
  assign samp = (rxs_q & rxs_prev_q) | (rxs_q & rxs_prev2_q) | (rxs_prev_q & rxs_prev2_q);
`else
  assign samp = rxs_q;
`endif

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= uart_rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          ferr_set;

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == BIT_END) ? '0 : cnt_q + CW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == START_PT) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = samp ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_END) begin
          shift_d[bit_q] = samp;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leaving at stop mid-bit leaves half a bit to catch a zero-gap start edge.
        if (cnt_q == BIT_END) begin
          if (samp) begin
            push_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
    end
  end

  assign rx_active = (state_q != ST_IDLE);

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overrun_q, frame_err_q;
  logic               pop, full, wr_en, ovr_set;

  assign pop     = rd_en && (count_q != '0);
  assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
  assign wr_en   = push_q && (!full || pop);
  assign ovr_set = push_q && full && !pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + (FIFO_AW+1)'(1);
    else if (!wr_en && pop) count_d = count_q - (FIFO_AW+1)'(1);
  end

  // Byte stays stable in shift_q during the push cycle; no separate holding register.
  always_ff @(posedge lpc_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q     <= count_d;
      overrun_q   <= (overrun_q & ~err_clr) | ovr_set;
      frame_err_q <= (frame_err_q & ~err_clr) | ferr_set;
    end
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven bit by bit, outputs sampled on the falling clock edge.
module tb_uart_rx_fifo;

  localparam int unsigned CPB = 64;
  localparam int unsigned MID = CPB / 2;

  logic       lpc_clk = 1'b0;
  logic       lpc_rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rd_en   = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       overrun;
  logic       frame_err;
  logic       rx_active;

  int checks   = 0;
  int failures = 0;

  always #5 lpc_clk = ~lpc_clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .lpc_clk   (lpc_clk),
    .lpc_rst   (lpc_rst),
    .uart_rx   (uart_rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr),
    .rx_active (rx_active)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge lpc_clk);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge lpc_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge lpc_clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge lpc_clk);
    err_clr = 1'b0;
  endtask

  initial begin
    int unsigned len;
    logic [7:0] b;

    idle(3);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_rx_active", rx_active, 0);
    lpc_rst = 1'b1;
    idle(10);

    // two frames, then read them back
    send_byte(8'h0F, 1'b1);
    send_byte(8'hA5, 1'b1);
    idle(4);
    check_eq("t1_count", count, 2);
    check_eq("t1_valid", rd_valid, 1);
    check_eq("t1_head0", rd_data, 8'h0F);
    pop();
    check_eq("t1_head1", rd_data, 8'hA5);
    check_eq("t1_count1", count, 1);
    pop();
    check_eq("t1_empty", rd_valid, 0);
    check_eq("t1_overrun", overrun, 0);
    check_eq("t1_frame_err", frame_err, 0);

    // zero-gap stream
    for (int i = 0; i < 5; i++) send_byte(8'hF6 + 8'(i), 1'b1);
    idle(4);
    check_eq("t2_count", count, 5);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_order", rd_data, 8'hF6 + 8'(i));
      pop();
    end
    check_eq("t2_frame_err", frame_err, 0);
    check_eq("t2_empty", rd_valid, 0);

    // 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    idle(4);
    check_eq("t3_count", count, 16);
    check_eq("t3_overrun", overrun, 1);
    check_eq("t3_head", rd_data, 8'h00);
    pulse_clr();
    check_eq("t3_overrun_clr", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      check_eq("t3_drain", rd_data, 8'(i));
      pop();
    end
    check_eq("t3_count_empty", count, 0);

    // short low glitch: START abandoned at mid-bit
    len = 0;
    uart_rx = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 20) uart_rx = 1'b1;
      @(negedge lpc_clk);
      if (rx_active) len++;
    end
    check_eq("t4_active_len_ok", (len >= MID && len <= MID + 3), 1);
    check_eq("t4_count", count, 0);
    check_eq("t4_idle", rx_active, 0);
    check_eq("t4_frame_err", frame_err, 0);

    // bad stop bit, then line held low
    send_byte(8'h55, 1'b0);
    idle(3000);
    uart_rx = 1'b1;
    idle(2 * CPB);
    check_eq("t5_frame_err", frame_err, 1);
    check_eq("t5_count", count, 0);
    check_eq("t5_idle", rx_active, 0);
    send_byte(8'hF1, 1'b1);
    idle(4);
    check_eq("t5_count_after", count, 1);
    check_eq("t5_data", rd_data, 8'hF1);
    check_eq("t5_sticky", frame_err, 1);
    pulse_clr();
    check_eq("t5_clr", frame_err, 0);
    pop();
    check_eq("t5_empty", rd_valid, 0);

    // reset asserted in the middle of data bit 4
    b = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    uart_rx = b[4];
    idle(MID);
    lpc_rst = 1'b0;
    idle(2);
    check_eq("t6_rst_active", rx_active, 0);
    check_eq("t6_rst_count", count, 0);
    idle(CPB - MID - 2);
    for (int i = 5; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
    lpc_rst = 1'b1;
    idle(10);
    check_eq("t6_idle", rx_active, 0);
    check_eq("t6_no_partial", count, 0);
    send_byte(8'hF2, 1'b1);
    idle(4);
    check_eq("t6_count", count, 1);
    check_eq("t6_data", rd_data, 8'hF2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
